fifo_rd_framer: RTL

//  Read-side consumer of the async FIFO, in the clk_rd domain. Pops 16-bit words through the FIFO
//  re/empty/dout port and packs them into frames on a valid/ready stream.

---
 rtl/fifo_rd_framer_pkg.sv | 19 +
 rtl/fifo_rd_framer_skid_buf2.sv | 55 +++++
 rtl/fifo_rd_framer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_rd_framer_pkg.sv
// Shared types for the FIFO read-side framer: word width, FSM states, output beat payload.
package fifo_rd_framer_pkg;

   localparam int unsigned DW          = 16;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CSUM = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } beat_t;

endpackage

// File: rtl/fifo_rd_framer_skid_buf2.sv
// Two-entry in-order buffer; head is the oldest entry, push and pop may coincide.
module fifo_rd_framer_skid_buf2
   import fifo_rd_framer_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [1:0]    occ,
   output logic [DW-1:0] head
);

   logic [DW-1:0] mem0;
   logic [DW-1:0] mem1;
   logic          pop_ok;

   assign pop_ok = pop && (occ != 2'd0);
   assign head   = mem0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ  <= 2'd0;
         mem0 <= '0;
         mem1 <= '0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (occ == 2'd0) begin
                  mem0 <= din;
                  occ  <= 2'd1;
               end else if (occ == 2'd1) begin
                  mem1 <= din;
                  occ  <= 2'd2;
               end
            end
            2'b01: begin
               mem0 <= mem1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new word lands behind whatever stays
               if (occ == 2'd1) begin
                  mem0 <= din;
               end else begin
                  mem0 <= mem1;
                  mem1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops words from the async FIFO read port and emits frames of up to BURST_LEN words
// followed by a wrap-around checksum beat; partial frames close after an idle timeout.
module fifo_rd_framer
   import fifo_rd_framer_pkg::*;
#(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                   clk_rd,
   input  logic                   rst_r,
   input  logic                   fifo_empty,
   output logic                   fifo_re,
   input  logic [DW-1:0]          fifo_dout,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DW-1:0]          m_data,
   output logic                   m_sop,
   output logic                   m_eop,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned CW = $clog2(BURST_LEN + 1);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   state_t        state;
   state_t        state_nx;
   beat_t         beat;
   logic          valid;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] wd_cnt;
   logic [IW-1:0] idle_cnt;
   logic [DW-1:0] csum;
   logic          inflight;
   logic [1:0]    occ;
   logic [DW-1:0] head;
   logic          pop;
   logic          idle;
   logic          csum_done;
   logic [2:0]    credit_used;

   fifo_rd_framer_skid_buf2 u_buf (
      .clk  (clk_rd),
      .rst  (rst_r),
      .push (inflight),
      .pop  (pop),
      .din  (fifo_dout),
      .occ  (occ),
      .head (head)
   );

   assign pop         = (state == DATA) && (occ != 2'd0) && m_ready;
   assign csum_done   = (state == CSUM) && m_ready;
   assign idle        = (occ == 2'd0) && !inflight && fifo_empty;
   assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);

   // Read credit: never more than two words held or in flight after this cycle.
   assign fifo_re = !rst_r && !fifo_empty && (state != CSUM) &&
                    (rd_cnt < CW'(BURST_LEN)) && (credit_used < 3'd2);

   always_ff @(posedge clk_rd or posedge rst_r) begin
      if (rst_r) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      valid     = 1'b0;
      beat      = '0;
      beat.data = head;
      case (state)
         IDLE: begin
            if (occ != 2'd0) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            valid    = (occ != 2'd0);
            beat.sop = valid && (wd_cnt == '0);
            if (pop && (wd_cnt == CW'(BURST_LEN - 1))) begin
               state_nx = CSUM;
            end else if ((idle_cnt == IW'(TIMEOUT)) && (wd_cnt != '0)) begin
               state_nx = CSUM;
            end
         end
         CSUM: begin
            valid     = 1'b1;
            beat.data = csum;
            beat.eop  = 1'b1;
            if (m_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign m_valid = valid;
   assign m_data  = beat.data;
   assign m_sop   = beat.sop;
   assign m_eop   = beat.eop;

   // Frame counters, checksum and the one-cycle read-latency tracker.
   always_ff @(posedge clk_rd or posedge rst_r) begin
      if (rst_r) begin
         inflight  <= 1'b0;
         rd_cnt    <= '0;
         wd_cnt    <= '0;
         idle_cnt  <= '0;
         csum      <= '0;
         frame_cnt <= '0;
      end else begin
         inflight <= fifo_re;
         if (fifo_re) begin
            rd_cnt <= rd_cnt + CW'(1);
         end
         if (pop) begin
            wd_cnt <= wd_cnt + CW'(1);
            csum   <= csum + head;
         end
         if (!idle) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + IW'(1);
         end
         if (csum_done) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            csum      <= '0;
            wd_cnt    <= '0;
            rd_cnt    <= '0;
            idle_cnt  <= '0;
         end
      end
   end

endmodule
